// File: rtl/karatsuba_mul32_seq.sv
// Sequenced 32x32 carry-less multiplier: one shared 16x16 Karatsuba core reused over three cycles.
// Optional accumulate-and-clear mode is enabled by defining KMUL_ACCUM_EN.

module karasubapoly_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [30:0] p
);
    localparam int unsigned Q = 8;
    localparam int unsigned QP = 2 * Q - 1;
    localparam int unsigned PW = 31;

    function automatic logic [QP-1:0] clmul8(input logic [Q-1:0] x, input logic [Q-1:0] y);
        logic [QP-1:0] r;
        r = '0;
        for (int i = 0; i < int'(Q); i++) begin
            if (y[i]) r = r ^ (QP'(x) << i);
        end
        return r;
    endfunction

    logic [QP-1:0] p_hi;
    logic [QP-1:0] p_lo;
    logic [QP-1:0] p_md;

    // One Karatsuba level over 8-bit schoolbook partial products
    always_comb begin
        p_hi = clmul8(a[15:8], b[15:8]);
        p_lo = clmul8(a[7:0], b[7:0]);
        p_md = clmul8(a[15:8] ^ a[7:0], b[15:8] ^ b[7:0]);
        p    = (PW'(p_hi) << 16) ^ (PW'(p_hi ^ p_lo ^ p_md) << 8) ^ PW'(p_lo);
    end
endmodule

module karatsuba_mul32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
`ifdef KMUL_ACCUM_EN
    input  logic        in_clr,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [62:0] out_data
);
    localparam int unsigned HALF  = 16;
    localparam int unsigned WIDTH = 2 * HALF;
    localparam int unsigned PHW   = 2 * HALF - 1;
    localparam int unsigned RW    = 2 * WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_HH,
        S_MUL_LL,
        S_MUL_MID,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [PHW-1:0]    p_hh_q;
    logic [PHW-1:0]    p_ll_q;
    logic [HALF-1:0]   mul_a;
    logic [HALF-1:0]   mul_b;
    logic [PHW-1:0]    mul_p;
    logic [PHW-1:0]    mid;
    logic [RW-1:0]     result;
`ifdef KMUL_ACCUM_EN
    logic              clr_q;
    logic [RW-1:0]     acc_q;
`endif

    karasubapoly_16 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Next state and shared-multiplier operand mux; idle/done hold operands at zero
    always_comb begin
        state_nxt = state;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_MUL_HH;
            end
            S_MUL_HH: begin
                mul_a     = a_q[WIDTH-1:HALF];
                mul_b     = b_q[WIDTH-1:HALF];
                state_nxt = S_MUL_LL;
            end
            S_MUL_LL: begin
                mul_a     = a_q[HALF-1:0];
                mul_b     = b_q[HALF-1:0];
                state_nxt = S_MUL_MID;
            end
            S_MUL_MID: begin
                mul_a     = a_q[WIDTH-1:HALF] ^ a_q[HALF-1:0];
                mul_b     = b_q[WIDTH-1:HALF] ^ b_q[HALF-1:0];
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // P_mid is the live multiplier output during MUL_MID; it lands directly in out_data
        mid    = p_hh_q ^ p_ll_q ^ mul_p;
        result = (RW'(p_hh_q) << WIDTH) ^ (RW'(mid) << HALF) ^ RW'(p_ll_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_hh_q    <= '0;
            p_ll_q    <= '0;
`ifdef KMUL_ACCUM_EN
            clr_q     <= 1'b0;
            acc_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
`ifdef KMUL_ACCUM_EN
                        clr_q <= in_clr;
`endif
                    end
                end
                S_MUL_HH: p_hh_q <= mul_p;
                S_MUL_LL: p_ll_q <= mul_p;
                S_MUL_MID: begin
`ifdef KMUL_ACCUM_EN
                    out_data <= result ^ (clr_q ? '0 : acc_q);
`else
                    out_data <= result;
`endif
                end
                S_DONE: begin
`ifdef KMUL_ACCUM_EN
                    // Accumulator only advances when the consumer actually takes the result
                    if (out_ready) acc_q <= out_data;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_mul32_seq.sv
// Scoreboard bench for karatsuba_mul32_seq: driver pushes expected products, monitor pops on handshake.
// Exercises accumulate mode as well when KMUL_ACCUM_EN is defined.

module tb_karatsuba_mul32_seq;
`ifdef KMUL_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
`ifdef KMUL_ACCUM_EN
    logic        in_clr;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [62:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [62:0] exp_q[$];
    logic [62:0] acc_m = '0;

    always #5 clk = ~clk;

    karatsuba_mul32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef KMUL_ACCUM_EN
        .in_clr    (in_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h required 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [62:0] clmul32(input logic [31:0] a, input logic [31:0] b);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (63'(a) << i);
        return r;
    endfunction

    // Waits (bounded) for in_ready, presents one operand pair for a single cycle
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic clr,
                        input logic [62:0] exp, input bit push);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            check("send_timeout_in_ready", 63'(in_ready), 63'(1));
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
`ifdef KMUL_ACCUM_EN
        in_clr   = clr;
`endif
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // r is the plain product; folds in the accumulator model when accumulate mode is built
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic clr, input logic [62:0] r);
        logic [62:0] e;
        e = (clr || !ACCUM) ? r : (r ^ acc_m);
        acc_m = e;
        send(a, b, clr, e, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue_empty", 63'(exp_q.size()), 63'(0));
    endtask

    // Monitor: every accepted output must match the oldest outstanding expectation
    initial begin
        logic [62:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%016h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", out_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
`ifdef KMUL_ACCUM_EN
        in_clr    = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 63'(in_ready), 63'(1));
        check("reset_out_valid", 63'(out_valid), 63'(0));
        check("reset_out_data", out_data, 63'(0));
        rst = 1'b0;

        // First op also measures accept-to-valid latency
        op(32'h0000_0003, 32'h0000_0003, 1'b1, 63'h0000000000000005);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        check("latency_cycles", 63'(k), 63'(4));

        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 63'h00000000FFFFFFFF);
        op(32'h0001_0000, 32'h0001_0000, 1'b1, 63'h0000000100000000);
        op(32'h8000_0000, 32'h8000_0000, 1'b1, 63'h4000000000000000);
        op(32'h0000_0005, 32'h0000_0007, 1'b1, 63'h000000000000001B);
        op(32'h0001_0001, 32'h0001_0001, 1'b1, 63'h0000000100000001);
        op(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 63'h0000555555550000);
        op(32'h0000_ABCD, 32'h0001_0000, 1'b1, 63'h00000000ABCD0000);
        op(32'h1234_5678, 32'h0000_0000, 1'b1, 63'h0000000000000000);
        drain();

        // Backpressure: result held, in_ready low, in_valid pulses ignored
        @(posedge clk); #1;
        out_ready = 1'b0;
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 63'h5555555555555555);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        check("bp_valid_seen", 63'(out_valid), 63'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a     = 32'h0000_0003 + 32'(i);
            in_b     = 32'h0000_0005;
            @(negedge clk);
            check("bp_out_valid", 63'(out_valid), 63'(1));
            check("bp_out_data", out_data, 63'h5555555555555555);
            check("bp_in_ready", 63'(in_ready), 63'(0));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while in MUL_LL aborts the op with no output
        send(32'h0000_0003, 32'h0000_0003, 1'b1, 63'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_m = '0;
        check("abort_in_ready", 63'(in_ready), 63'(1));
        check("abort_out_valid", 63'(out_valid), 63'(0));
        check("abort_out_data", out_data, 63'(0));
        repeat (12) @(posedge clk);
        #1;
        check("abort_still_idle", 63'(in_ready), 63'(1));

`ifdef KMUL_ACCUM_EN
        send(32'h1, 32'h3 ^ 32'h2, 1'b1, 63'h1, 1'b1);
        send(32'h3, 32'h3, 1'b1, 63'h5, 1'b1);
        send(32'h1, 32'h1, 1'b0, 63'h4, 1'b1);
        send(32'h1, 32'h1, 1'b1, 63'h1, 1'b1);
        acc_m = 63'h1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = ($urandom_range(0, 7) == 0);
            op(ra, rb, rc, clmul32(ra, rb));
        end
`else
        op(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 63'h00000000DEADBEEF);
        ra = 32'hA5A5_1234;
        rb = 32'h0F0F_00FF;
        rc = 1'b1;
        op(ra, rb, rc, clmul32(ra, rb));
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
